serv_rf_ram_resp: RTL and testbench

RAM-side responder for the SERV register-file RAM interface. It stores GPR and CSR bits as width-bit words. It accepts the write and read address/data/enable signals driven by the RAM-side of the rf RAM interface and returns registered read data with exactly one cycle of latency. After every reset it clears all storage to zero, signalling completion on o_init_done. It also offers a low-priority debug read port that steals idle read cycles for bench and debugger access.

---
 rtl/serv_rf_pkg.sv | 15 +
 rtl/serv_rf_ram_array.sv | 27 ++
 rtl/serv_rf_ram_resp.sv | 139 +++++++++++++
 tb/tb_serv_rf_ram_resp.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serv_rf_pkg.sv
// Shared sizing helpers and clear-FSM state encoding for the SERV rf RAM responder.
package serv_rf_pkg;

   localparam logic ST_CLEAR = 1'b0;
   localparam logic ST_RUN   = 1'b1;

   function automatic int rf_depth(input int width, input int csr_regs);
      return 32 * (32 + csr_regs) / width;
   endfunction

   function automatic int rf_aw(input int width, input int csr_regs);
      return 5 + $clog2(32 + csr_regs) - $clog2(width);
   endfunction

endpackage

// File: rtl/serv_rf_ram_array.sv
// 1W1R synchronous word array with registered read port; a same-address
// read and write in one cycle returns the previous contents.
module serv_rf_ram_array #(
   parameter int width = 8,
   parameter int depth = 144,
   parameter int aw    = 8
)(
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [aw-1:0]    i_waddr,
   input  logic [width-1:0] i_wdata,
   input  logic             i_re,
   input  logic [aw-1:0]    i_raddr,
   output logic [width-1:0] o_rdata
);

   logic [width-1:0] mem [depth];

   // No reset so the array maps onto block RAM; callers only read in-range words.
   always_ff @(posedge i_clk) begin
      if (i_we)
         mem[i_waddr] <= i_wdata;
      if (i_re)
         o_rdata <= mem[i_raddr];
   end

endmodule

// File: rtl/serv_rf_ram_resp.sv
// RAM-side responder for the SERV rf RAM interface: zero-fill after reset,
// one-cycle registered reads, and a debug port that borrows idle read cycles.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | writing 0 to word[clr_cnt]; user writes, reads, debug ignored
// ST_RUN   | normal operation; o_init_done high
module serv_rf_ram_resp
   import serv_rf_pkg::*;
#(
   parameter int width          = 8,
   parameter int csr_regs       = 4,
   parameter int depth          = rf_depth(width, csr_regs),
   parameter int aw             = rf_aw(width, csr_regs),
   parameter bit clear_on_reset = 1'b1
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [aw-1:0]    i_waddr,
   input  logic [width-1:0] i_wdata,
   input  logic             i_wen,
   input  logic [aw-1:0]    i_raddr,
   input  logic             i_ren,
   output logic [width-1:0] o_rdata,
   output logic             o_init_done,
   input  logic             i_dbg_req,
   input  logic [aw-1:0]    i_dbg_addr,
   output logic             o_dbg_ack,
   output logic [width-1:0] o_dbg_data
);

   localparam logic [aw-1:0] LAST_ADDR = aw'(depth - 1);
   localparam logic          RST_STATE = clear_on_reset ? ST_CLEAR : ST_RUN;
   localparam int unsigned   DEPTH_U   = depth;

   logic             state;
   logic             next_state;
   logic [aw-1:0]    clr_cnt;

   logic             mem_we;
   logic [aw-1:0]    mem_waddr;
   logic [width-1:0] mem_wdata;
   logic             mem_re;
   logic [aw-1:0]    mem_raddr;
   logic [width-1:0] mem_rdata;
   logic             rd_zero;
   logic             dbg_issue;

   logic             user_vld_q;
   logic             dbg_vld_q;
   logic             rd_zero_q;
   logic             init_done_q;
   logic [width-1:0] rdata_hold_q;
   logic [width-1:0] dbg_hold_q;

   function automatic logic in_range(input logic [aw-1:0] addr);
      return 32'(addr) < DEPTH_U;
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= RST_STATE;
         clr_cnt <= '0;
      end else begin
         state <= next_state;
         if (state == ST_CLEAR)
            clr_cnt <= clr_cnt + aw'(1);
      end
   end

   always_comb begin
      next_state = state;
      if (state == ST_CLEAR && clr_cnt == LAST_ADDR)
         next_state = ST_RUN;
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = i_waddr;
      mem_wdata = i_wdata;
      mem_raddr = i_raddr;
      mem_re    = 1'b0;
      rd_zero   = 1'b1;
      dbg_issue = 1'b0;
      if (state == ST_CLEAR) begin
         mem_we    = !i_rst;
         mem_waddr = clr_cnt;
         mem_wdata = '0;
      end else begin
         mem_we    = i_wen && in_range(i_waddr) && !i_rst;
         // Debug only gets the read port when the user leaves it idle and the
         // previous debug ack is not still in flight.
         dbg_issue = i_dbg_req && !i_ren && !dbg_vld_q;
         if (dbg_issue)
            mem_raddr = i_dbg_addr;
         rd_zero   = !in_range(mem_raddr);
         mem_re    = (i_ren || dbg_issue) && !rd_zero;
      end
   end

   serv_rf_ram_array #(
      .width (width),
      .depth (depth),
      .aw    (aw)
   ) u_array (
      .i_clk   (i_clk),
      .i_we    (mem_we),
      .i_waddr (mem_waddr),
      .i_wdata (mem_wdata),
      .i_re    (mem_re),
      .i_raddr (mem_raddr),
      .o_rdata (mem_rdata)
   );

   // The array output is shared, so each consumer keeps its own hold copy.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         user_vld_q   <= 1'b0;
         dbg_vld_q    <= 1'b0;
         rd_zero_q    <= 1'b0;
         init_done_q  <= 1'b0;
         rdata_hold_q <= '0;
         dbg_hold_q   <= '0;
      end else begin
         user_vld_q   <= i_ren;
         dbg_vld_q    <= dbg_issue;
         rd_zero_q    <= rd_zero;
         init_done_q  <= (next_state == ST_RUN);
         rdata_hold_q <= o_rdata;
         dbg_hold_q   <= o_dbg_data;
      end
   end

   assign o_rdata     = user_vld_q ? (rd_zero_q ? '0 : mem_rdata) : rdata_hold_q;
   assign o_dbg_data  = dbg_vld_q  ? (rd_zero_q ? '0 : mem_rdata) : dbg_hold_q;
   assign o_dbg_ack   = dbg_vld_q;
   assign o_init_done = init_done_q;

endmodule

// File: tb/tb_serv_rf_ram_resp.sv
// Directed bench for serv_rf_ram_resp with a read-data scoreboard and word model.
module tb_serv_rf_ram_resp;

   localparam int DEPTH = 144;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [7:0] i_waddr = '0;
   logic [7:0] i_wdata = '0;
   logic       i_wen = 1'b0;
   logic [7:0] i_raddr = '0;
   logic       i_ren = 1'b0;
   logic [7:0] o_rdata;
   logic       o_init_done;
   logic       i_dbg_req = 1'b0;
   logic [7:0] i_dbg_addr = '0;
   logic       o_dbg_ack;
   logic [7:0] o_dbg_data;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] model [DEPTH];
   logic [7:0] exp_q [$];
   int         n;
   logic [7:0] ra, wa, wd;
   logic       we, re;

   serv_rf_ram_resp dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_waddr     (i_waddr),
      .i_wdata     (i_wdata),
      .i_wen       (i_wen),
      .i_raddr     (i_raddr),
      .i_ren       (i_ren),
      .o_rdata     (o_rdata),
      .o_init_done (o_init_done),
      .i_dbg_req   (i_dbg_req),
      .i_dbg_addr  (i_dbg_addr),
      .o_dbg_ack   (o_dbg_ack),
      .o_dbg_data  (o_dbg_data)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] obs);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         chk(tag, {24'd0, obs}, {24'd0, e});
      end
   endtask

   function automatic logic [7:0] mdl_rd(input logic [7:0] a);
      return (int'(a) < DEPTH) ? model[a] : 8'h00;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      i_wen = 1'b1; i_waddr = a; i_wdata = d;
      tick();
      i_wen = 1'b0;
      if (int'(a) < DEPTH) model[a] = d;
   endtask

   task automatic do_read(input logic [7:0] a, input string tag);
      i_ren = 1'b1; i_raddr = a;
      exp_q.push_back(mdl_rd(a));
      tick();
      i_ren = 1'b0;
      pop_chk(tag, o_rdata);
   endtask

   task automatic do_dbg(input logic [7:0] a, input string tag);
      int k;
      i_dbg_req = 1'b1; i_dbg_addr = a;
      exp_q.push_back(mdl_rd(a));
      k = 0;
      do begin
         tick();
         k++;
      end while (!o_dbg_ack && k < 20);
      chk({tag, " ack"}, {31'd0, o_dbg_ack}, 32'd1);
      pop_chk(tag, o_dbg_data);
      i_dbg_req = 1'b0;
   endtask

   task automatic wait_init(input string tag);
      int k;
      k = 0;
      while (!o_init_done && k < 1000) begin
         tick();
         k++;
      end
      chk(tag, k, 32'd144);
   endtask

   initial begin
      clear_model();

      // Reset values
      repeat (3) tick();
      chk("rst rdata", {24'd0, o_rdata}, 32'd0);
      chk("rst init_done", {31'd0, o_init_done}, 32'd0);
      chk("rst dbg_ack", {31'd0, o_dbg_ack}, 32'd0);
      chk("rst dbg_data", {24'd0, o_dbg_data}, 32'd0);

      // Clear phase: user writes, reads and debug must all be inert
      i_rst = 1'b0;
      n = 0;
      while (!o_init_done && n < 1000) begin
         i_wen = 1'b1; i_waddr = 8'd5; i_wdata = 8'hFF;
         i_ren = 1'b1; i_raddr = 8'(n);
         i_dbg_req = 1'b1; i_dbg_addr = 8'd1;
         tick();
         n++;
         chk("clear rdata zero", {24'd0, o_rdata}, 32'd0);
         chk("clear no dbg ack", {31'd0, o_dbg_ack}, 32'd0);
      end
      i_wen = 1'b0; i_ren = 1'b0; i_dbg_req = 1'b0;
      chk("init cycles", n, 32'd144);

      for (int a = 0; a < DEPTH; a++) do_dbg(8'(a), "post-init sweep");

      // Write then read back
      do_write(8'd3, 8'hA5);
      do_read(8'd3, "rd addr3");

      // Read-during-write returns old data
      do_write(8'd7, 8'h11);
      i_wen = 1'b1; i_waddr = 8'd7; i_wdata = 8'h22;
      i_ren = 1'b1; i_raddr = 8'd7;
      exp_q.push_back(mdl_rd(8'd7));
      tick();
      i_wen = 1'b0; i_ren = 1'b0;
      model[7] = 8'h22;
      pop_chk("rdw old data", o_rdata);
      do_read(8'd7, "rdw new data");

      // Debug starved by i_ren, then served
      do_write(8'd10, 8'h5C);
      do_read(8'd3, "rd addr3 again");
      i_dbg_req = 1'b1; i_dbg_addr = 8'd10;
      for (int k = 0; k < 5; k++) begin
         i_ren = 1'b1; i_raddr = 8'd3;
         exp_q.push_back(mdl_rd(8'd3));
         tick();
         pop_chk("starve rdata", o_rdata);
         chk("starve no ack", {31'd0, o_dbg_ack}, 32'd0);
      end
      i_ren = 1'b0;
      tick();
      chk("dbg ack after starve", {31'd0, o_dbg_ack}, 32'd1);
      chk("dbg data 10", {24'd0, o_dbg_data}, 32'h5C);
      chk("rdata held", {24'd0, o_rdata}, 32'hA5);
      tick();
      chk("no reissue in ack cycle", {31'd0, o_dbg_ack}, 32'd0);
      tick();
      chk("reissue ack", {31'd0, o_dbg_ack}, 32'd1);
      chk("reissue data", {24'd0, o_dbg_data}, 32'h5C);
      i_dbg_req = 1'b0;
      tick();
      chk("ack one pulse", {31'd0, o_dbg_ack}, 32'd0);
      chk("dbg data held", {24'd0, o_dbg_data}, 32'h5C);

      // Out-of-range accesses
      do_write(8'd200, 8'hFF);
      do_read(8'd200, "rd oor 200");
      do_read(8'd56, "rd alias 56");
      do_read(8'd3, "rd addr3 nz");
      do_read(8'd255, "rd oor 255");
      do_dbg(8'd10, "dbg 10");
      do_dbg(8'd200, "dbg oor 200");
      do_dbg(8'd143, "dbg last");

      // Mixed random traffic
      for (int k = 0; k < 40; k++) begin
         we = 1'($urandom_range(0, 1));
         re = 1'($urandom_range(0, 1));
         wa = 8'($urandom_range(0, 159));
         wd = 8'($urandom_range(0, 255));
         ra = (k % 3 == 0) ? wa : 8'($urandom_range(0, 159));
         i_wen = we; i_waddr = wa; i_wdata = wd;
         i_ren = re; i_raddr = ra;
         if (re) exp_q.push_back(mdl_rd(ra));
         tick();
         if (we && int'(wa) < DEPTH) model[wa] = wd;
         if (re) pop_chk("rand rd", o_rdata);
      end
      i_wen = 1'b0; i_ren = 1'b0;
      for (int a = 0; a < DEPTH; a++) do_dbg(8'(a), "model sweep");
      chk("init_done stays high", {31'd0, o_init_done}, 32'd1);

      // Reset in the middle of a clear
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      repeat (50) tick();
      chk("mid-clear not done", {31'd0, o_init_done}, 32'd0);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk("re-reset init low", {31'd0, o_init_done}, 32'd0);
      wait_init("re-clear cycles");
      clear_model();
      for (int a = 0; a < DEPTH; a++) do_dbg(8'(a), "re-clear sweep");
      do_read(8'd10, "re-clear rd10");

      chk("scoreboard drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
